// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
package instr_fetch_unit_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    // Instruction addresses are word aligned; the low two bits are dropped.
    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return addr & ~32'h3;
    endfunction

endpackage

// File: rtl/instr_fetch_unit_fetch_queue.sv
// Circular fetch queue of {pc, instr} entries with push, pop and flush.
module fetch_queue
    import instr_fetch_unit_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  fetch_entry_t     wr_data,
    output fetch_entry_t     rd_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    // NOTE: storage is reset too, so the head reads as zero straight out of reset.
    // NOTE: all state uses non-blocking assignments so every update sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    assign rd_data = mem[rd_ptr];
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC, redirect mux and fetch queue feeding decode.
// Optional bounds check is compiled in with `define IFU_BOUNDS_CHECK_EN.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          FQ_DEPTH   = 4,
    parameter int          IMEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        dec_valid,
    output logic [31:0] dec_instr,
    output logic [31:0] dec_pc,
    input  logic        dec_ready,
    output logic        fetch_fault
);

    localparam int CNT_W = $clog2(FQ_DEPTH + 1);

    logic [31:0]      pc;
    logic             fault_state;
    logic             can_fetch;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    logic [CNT_W-1:0] count;
    fetch_entry_t     head;
    fetch_entry_t     wr_entry;

    assign pop = dec_valid & dec_ready;

    // A full queue may still fetch when decode frees the head in the same cycle.
    assign can_fetch = !redirect_valid && !fault_state && (!full || pop);

`ifdef IFU_BOUNDS_CHECK_EN
    localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_WORDS * 4);

    logic out_of_bounds;
    assign out_of_bounds = (pc >= IMEM_LIMIT);
    assign push          = can_fetch && !out_of_bounds;

    // Sticky until a redirect supplies a fresh target.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_state <= 1'b0;
        end else if (redirect_valid) begin
            fault_state <= 1'b0;
        end else if (can_fetch && out_of_bounds) begin
            fault_state <= 1'b1;
        end
    end
`else
    assign push        = can_fetch;
    assign fault_state = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= align_word(RESET_PC);
        end else if (redirect_valid) begin
            pc <= align_word(redirect_pc);
        end else if (push) begin
            pc <= pc + 32'd4;
        end
    end

    assign wr_entry = '{pc: pc, instr: imem_rdata};

    fetch_queue #(
        .DEPTH (FQ_DEPTH)
    ) u_fetch_queue (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .flush   (redirect_valid),
        .wr_data (wr_entry),
        .rd_data (head),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    assign imem_addr   = pc;
    assign dec_valid   = !empty;
    assign dec_instr   = head.instr;
    assign dec_pc      = head.pc;
    assign fetch_fault = fault_state;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: vector table, corner sequences and a queue scoreboard.
module tb_instr_fetch_unit;
    import instr_fetch_unit_pkg::*;

    localparam int          FQ_DEPTH   = 4;
    localparam int          IMEM_WORDS = 64;
    localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        dec_valid;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic        dec_ready = 1'b0;
    logic        fetch_fault;

    int checks   = 0;
    int failures = 0;

    logic [31:0] imem [IMEM_WORDS];

    always #5 clk = ~clk;

    assign imem_rdata = imem[imem_addr[7:2]];

    instr_fetch_unit #(
        .RESET_PC   (TB_RESET_PC),
        .FQ_DEPTH   (FQ_DEPTH),
        .IMEM_WORDS (IMEM_WORDS)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec_valid      (dec_valid),
        .dec_instr      (dec_instr),
        .dec_pc         (dec_pc),
        .dec_ready      (dec_ready),
        .fetch_fault    (fetch_fault)
    );

    // Memory image: word i holds 0x11*(i+1).
    function automatic logic [31:0] instr_of(input logic [31:0] addr);
        logic [5:0] idx;
        idx = addr[7:2];
        return 32'h11 * (32'(idx) + 32'd1);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Scoreboard: entries are pushed when the model predicts a fetch and popped on decode accept.
    fetch_entry_t sb_q [$];
    logic [31:0]  m_pc;
    logic         m_fault;

    task automatic model_reset();
        sb_q.delete();
        m_pc    = TB_RESET_PC & ~32'h3;
        m_fault = 1'b0;
    endtask

    task automatic model_compare(input string tag);
        check({tag, ".sb_valid"}, 32'(dec_valid), 32'(sb_q.size() != 0));
        if (sb_q.size() != 0) begin
            check({tag, ".sb_pc"}, dec_pc, sb_q[0].pc);
            check({tag, ".sb_instr"}, dec_instr, sb_q[0].instr);
        end
        check({tag, ".sb_addr"}, imem_addr, m_pc);
        check({tag, ".sb_fault"}, 32'(fetch_fault), 32'(m_fault));
    endtask

    task automatic model_update();
        bit pop;
        bit can;
        pop = (sb_q.size() != 0) && dec_ready;
        if (redirect_valid) begin
            sb_q.delete();
            m_pc    = redirect_pc & ~32'h3;
            m_fault = 1'b0;
        end else begin
            can = !m_fault && ((sb_q.size() < FQ_DEPTH) || pop);
            if (pop) void'(sb_q.pop_front());
            if (can) begin
`ifdef IFU_BOUNDS_CHECK_EN
                if (m_pc >= 32'(IMEM_WORDS * 4)) begin
                    m_fault = 1'b1;
                end else begin
                    sb_q.push_back('{pc: m_pc, instr: instr_of(m_pc)});
                    m_pc = m_pc + 32'd4;
                end
`else
                sb_q.push_back('{pc: m_pc, instr: instr_of(m_pc)});
                m_pc = m_pc + 32'd4;
`endif
            end
        end
    endtask

    // Drive inputs just after a rising edge, then sample on the falling edge.
    task automatic cyc(input logic rdy, input logic rv, input logic [31:0] rpc, input string tag);
        dec_ready      = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        @(negedge clk);
        model_compare(tag);
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        #1;
        check("rst.valid", 32'(dec_valid), 32'd0);
        check("rst.instr", dec_instr, 32'd0);
        check("rst.pc", dec_pc, 32'd0);
        check("rst.fault", 32'(fetch_fault), 32'd0);
        check("rst.addr", imem_addr, TB_RESET_PC & ~32'h3);
        dec_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    typedef struct {
        bit          rst_before;
        logic        rdy;
        logic        rv;
        logic [31:0] rpc;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t vecs [$];

    task automatic add(input bit r, input logic rdy, input logic rv, input logic [31:0] rpc,
                       input logic ev, input logic [31:0] epc, input logic [31:0] eaddr);
        vec_t v;
        v.rst_before = r;
        v.rdy        = rdy;
        v.rv         = rv;
        v.rpc        = rpc;
        v.exp_valid  = ev;
        v.exp_pc     = epc;
        v.exp_addr   = eaddr;
        vecs.push_back(v);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < IMEM_WORDS; i++) begin
            imem[i] = 32'h11 * 32'(i + 1);
        end

        // Streaming with decode always ready.
        add(1, 1, 0, 0, 0, 0, 32'h00);
        add(0, 1, 0, 0, 1, 32'h00, 32'h04);
        add(0, 1, 0, 0, 1, 32'h04, 32'h08);
        add(0, 1, 0, 0, 1, 32'h08, 32'h0C);
        add(0, 1, 0, 0, 1, 32'h0C, 32'h10);
        add(0, 1, 0, 0, 1, 32'h10, 32'h14);
        // Decode stalled: queue fills, PC freezes at 0x10, then drains in order.
        add(1, 0, 0, 0, 0, 0, 32'h00);
        add(0, 0, 0, 0, 1, 32'h00, 32'h04);
        add(0, 0, 0, 0, 1, 32'h00, 32'h08);
        add(0, 0, 0, 0, 1, 32'h00, 32'h0C);
        for (int i = 0; i < 6; i++) add(0, 0, 0, 0, 1, 32'h00, 32'h10);
        add(0, 1, 0, 0, 1, 32'h00, 32'h10);
        add(0, 1, 0, 0, 1, 32'h04, 32'h14);
        add(0, 1, 0, 0, 1, 32'h08, 32'h18);
        add(0, 1, 0, 0, 1, 32'h0C, 32'h1C);
        add(0, 1, 0, 0, 1, 32'h10, 32'h20);
        // Redirect to 0x40 with three entries queued.
        add(1, 0, 0, 0, 0, 0, 32'h00);
        add(0, 0, 0, 0, 1, 32'h00, 32'h04);
        add(0, 0, 0, 0, 1, 32'h00, 32'h08);
        add(0, 0, 1, 32'h40, 1, 32'h00, 32'h0C);
        add(0, 1, 0, 0, 0, 0, 32'h40);
        add(0, 1, 0, 0, 1, 32'h40, 32'h44);
        // Redirect, pop and full queue together; misaligned target 0x23.
        add(1, 0, 0, 0, 0, 0, 32'h00);
        add(0, 0, 0, 0, 1, 32'h00, 32'h04);
        add(0, 0, 0, 0, 1, 32'h00, 32'h08);
        add(0, 0, 0, 0, 1, 32'h00, 32'h0C);
        add(0, 1, 1, 32'h23, 1, 32'h00, 32'h10);
        add(0, 1, 0, 0, 0, 0, 32'h20);
        add(0, 1, 0, 0, 1, 32'h20, 32'h24);
        add(0, 1, 0, 0, 1, 32'h24, 32'h28);

        model_reset();
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst_before) reset_dut();
            cyc(vecs[i].rdy, vecs[i].rv, vecs[i].rpc, $sformatf("vec%0d", i));
            check($sformatf("vec%0d.valid", i), 32'(dec_valid), 32'(vecs[i].exp_valid));
            if (vecs[i].exp_valid) begin
                check($sformatf("vec%0d.pc", i), dec_pc, vecs[i].exp_pc);
                check($sformatf("vec%0d.instr", i), dec_instr, instr_of(vecs[i].exp_pc));
            end
            check($sformatf("vec%0d.addr", i), imem_addr, vecs[i].exp_addr);
            advance();
        end

        // Asynchronous reset with a full queue, asserted between clock edges.
        reset_dut();
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 0, "t5.fill");
            advance();
        end
        cyc(0, 0, 0, "t5.full");
        check("t5.full_valid", 32'(dec_valid), 32'd1);
        #2;
        reset_dut();
        cyc(1, 0, 0, "t5.c0");
        check("t5.c0_valid", 32'(dec_valid), 32'd0);
        advance();
        cyc(1, 0, 0, "t5.c1");
        check("t5.c1_valid", 32'(dec_valid), 32'd1);
        check("t5.c1_pc", dec_pc, TB_RESET_PC);
        advance();

`ifdef IFU_BOUNDS_CHECK_EN
        // Run off the end of memory, fault, then recover with a redirect to 0.
        reset_dut();
        cyc(1, 1, 32'hF8, "t6.c0");
        advance();
        cyc(1, 0, 0, "t6.c1");
        check("t6.c1_addr", imem_addr, 32'hF8);
        advance();
        cyc(1, 0, 0, "t6.c2");
        check("t6.c2_pc", dec_pc, 32'hF8);
        advance();
        cyc(1, 0, 0, "t6.c3");
        check("t6.c3_pc", dec_pc, 32'hFC);
        check("t6.c3_valid", 32'(dec_valid), 32'd1);
        advance();
        cyc(1, 1, 32'h0, "t6.c4");
        check("t6.c4_fault", 32'(fetch_fault), 32'd1);
        check("t6.c4_valid", 32'(dec_valid), 32'd0);
        advance();
        cyc(1, 0, 0, "t6.c5");
        check("t6.c5_fault", 32'(fetch_fault), 32'd0);
        advance();
        cyc(1, 0, 0, "t6.c6");
        check("t6.c6_valid", 32'(dec_valid), 32'd1);
        check("t6.c6_pc", dec_pc, 32'h0);
        advance();
`endif

        // Random decode stalls and redirects against the scoreboard.
        reset_dut();
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
                32'($urandom_range(0, 255)), "rnd");
            advance();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
